// File: rtl/muldiv_if.sv
// muldiv_if: issue/result handshake between the pipeline (master) and muldiv_unit (slave)
interface muldiv_if #(parameter int XLEN = 64);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master(output start, op, a, b, flush, input busy, done, result);
  modport slave(input start, op, a, b, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M mul/div/divu/rem/remu; define MULDIV_FAST_MUL_EN for single-cycle mul
module muldiv_unit #(parameter int XLEN = 64) (
  input logic      clk,
  input logic      reset,
  muldiv_if.slave  io
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] x, y, acc;
  logic [5:0]      cnt;
  logic            neg_q, neg_r;
  logic            is_div, is_sgn, is_rem, a_neg, b_neg, ovf, rem_q;
  logic [XLEN-1:0] a_mag, b_mag, mul_step, fix_q, fix_r;
  logic [XLEN:0]   r_sh, diff;
  assign is_div   = io.op >= 3'd1 && io.op <= 3'd4;
  assign is_sgn   = io.op == 3'd1 || io.op == 3'd3;
  assign is_rem   = io.op == 3'd3 || io.op == 3'd4;
  assign a_neg    = is_sgn & io.a[XLEN-1];
  assign b_neg    = is_sgn & io.b[XLEN-1];
  assign a_mag    = a_neg ? -io.a : io.a;
  assign b_mag    = b_neg ? -io.b : io.b;
  assign ovf      = is_sgn && io.a == {1'b1, {(XLEN-1){1'b0}}} && &io.b;
  assign mul_step = acc + (y[0] ? x : '0);
  // x carries the dividend out of its MSB and collects quotient bits at its LSB
  assign r_sh     = {acc, x[XLEN-1]};
  assign diff     = r_sh - {1'b0, y};
  assign rem_q    = op_q == 3'd3 || op_q == 3'd4;
  assign fix_q    = neg_q ? -x : x;
  assign fix_r    = neg_r ? -acc : acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= '0;
      x         <= '0;
      y         <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      io.busy   <= 1'b0;
      io.done   <= 1'b0;
      io.result <= '0;
    end else if (io.flush) begin
      state   <= IDLE;
      io.busy <= 1'b0;
      io.done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          op_q    <= io.op;
          cnt     <= '0;
          neg_q   <= a_neg ^ b_neg;
          neg_r   <= a_neg;
          io.busy <= 1'b1;
          if (!is_div) begin
`ifdef MULDIV_FAST_MUL_EN
            state     <= DONE;
            io.done   <= 1'b1;
            io.result <= io.a * io.b;
`else
            state <= MUL;
            x     <= io.a;
            y     <= io.b;
            acc   <= '0;
`endif
          end else if (io.b == '0) begin
            state     <= DONE;
            io.done   <= 1'b1;
            io.result <= is_rem ? io.a : '1;
          end else if (ovf) begin
            state     <= DONE;
            io.done   <= 1'b1;
            io.result <= is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          end else begin
            state <= DIV;
            x     <= a_mag;
            y     <= b_mag;
            acc   <= '0;
          end
        end
        MUL: begin
          acc <= mul_step;
          x   <= x << 1;
          y   <= y >> 1;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) begin
            state     <= DONE;
            io.done   <= 1'b1;
            io.result <= mul_step;
          end
        end
        DIV: begin
          acc <= diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
          x   <= {x[XLEN-2:0], ~diff[XLEN]};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd63) state <= FIX;
        end
        FIX: begin
          state     <= DONE;
          io.done   <= 1'b1;
          io.result <= rem_q ? fix_r : fix_q;
        end
        DONE: begin
          state   <= IDLE;
          io.busy <= 1'b0;
          io.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results and latencies
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 65;
`endif
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int n;
  logic saw_done;
  muldiv_if #(.XLEN(64)) io();
  muldiv_unit #(.XLEN(64)) dut(.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    check("idle_busy", {63'd0, io.busy}, 64'd0);
    io.start = 1'b1;
    io.op = op;
    io.a = a;
    io.b = b;
    @(negedge clk);
    io.start = 1'b0;
    n = 1;
  endtask
  task automatic finish(input string tag, input logic [63:0] exp, input int lat);
    while (!io.done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, io.result, exp);
    check({tag, "_busy"}, {63'd0, io.busy}, 64'd1);
  endtask
  task automatic run(input string tag, input logic [2:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp, input int lat);
    @(negedge clk);
    issue(op, a, b);
    finish(tag, exp, lat);
  endtask
  initial begin
    io.start = 1'b0;
    io.flush = 1'b0;
    io.op = '0;
    io.a = '0;
    io.b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {63'd0, io.busy}, 64'd0);
    check("rst_done", {63'd0, io.done}, 64'd0);
    check("rst_result", io.result, 64'd0);
    run("mul_neg", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT);
    run("mul_op5", 3'd5, 64'd6, 64'd7, 64'd42, MUL_LAT);
    run("div_neg", 3'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run("rem_neg", 3'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66);
    run("div_negb", 3'd1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    run("rem_negb", 3'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66);
    run("remu", 3'd4, 64'd100, 64'd7, 64'd2, 66);
    run("divu", 3'd2, 64'd100, 64'd7, 64'd14, 66);
    // flush mid-divide: no done, result keeps 14, then a mul issued right after completes
    @(negedge clk);
    issue(3'd1, 64'd1000, 64'd3);
    saw_done = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      saw_done |= io.done;
    end
    io.flush = 1'b1;
    @(negedge clk);
    io.flush = 1'b0;
    check("flush_nodone", {63'd0, saw_done | io.done}, 64'd0);
    check("flush_busy", {63'd0, io.busy}, 64'd0);
    check("flush_result", io.result, 64'd14);
    issue(3'd0, 64'd3, 64'd4);
    finish("mul_after_flush", 64'd12, MUL_LAT);
    run("divu_zero", 3'd2, 64'd5, 64'd0, ONES, 1);
    @(negedge clk);
    check("divu_zero_busy_t2", {63'd0, io.busy}, 64'd0);
    check("divu_zero_done_t2", {63'd0, io.done}, 64'd0);
    run("remu_zero", 3'd4, 64'd5, 64'd0, 64'd5, 1);
    run("div_zero", 3'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, ONES, 1);
    run("rem_zero", 3'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 1);
    run("div_ovf", 3'd1, MIN, ONES, MIN, 1);
    run("rem_ovf", 3'd3, MIN, ONES, 64'd0, 1);
    run("divu_min", 3'd2, MIN, ONES, 64'd0, 66);
    // start while busy must be ignored
    @(negedge clk);
    issue(3'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    while (!io.done && n < 200) begin
      if (n == 5) begin
        io.start = 1'b1;
        io.op = 3'd0;
        io.a = 64'd9;
        io.b = 64'd9;
      end
      if (n == 10) io.start = 1'b0;
      @(negedge clk);
      n++;
    end
    check("ign_lat", 64'(n), 64'd66);
    check("ign_res", io.result, 64'hFFFF_FFFF_FFFF_FFFD);
    // reset mid-divide clears everything on the next edge
    @(negedge clk);
    issue(3'd2, 64'd100, 64'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {63'd0, io.busy}, 64'd0);
    check("midrst_done", {63'd0, io.done}, 64'd0);
    check("midrst_result", io.result, 64'd0);
    run("divu_after_rst", 3'd2, 64'd100, 64'd7, 64'd14, 66);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV64M multiply/divide execution unit that sits directly downstream of the instruction decoder. The pipeline issues `mul`, `div`, `divu`, `rem` and `remu` to this block whenever the decoder flags a MULDIVREM instruction. The block holds the pipeline via `busy` until the result is ready, then returns a 64-bit value. The writeback mux selects that value for RD_M codes 5, 6 and 7.

## Interface
Parameters:
- XLEN, 64, operand/result width; only 64 is supported.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue request; sampled only in IDLE.
- op  input  3  0=mul, 1=div, 2=divu, 3=rem, 4=remu (decoder ALUop minus 15); 5-7 treated as mul.
- a  input  XLEN  rs1 value, captured on accepted start.
- b  input  XLEN  rs2 value, captured on accepted start.
- flush  input  1  abort in-flight operation (branch/jump redirect).
- busy  output  1  high whenever state != IDLE; the pipeline stalls on it.
- done  output  1  one-cycle pulse; result valid that cycle.
- result  output  XLEN  final value; held until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE + start: capture op, a, b; clear the iteration counter.
  - mul goes to MUL.
  - div/divu/rem/remu with b==0 goes straight to DONE with the special-case result.
  - Signed overflow (a==0x8000_0000_0000_0000, b==all-ones, div/rem) goes straight to DONE with the special-case result.
  - Otherwise div/divu/rem/remu go to DIV.
- MUL: shift-add, one multiplier bit per cycle, 64 cycles. Accumulate the low 64 bits only, since signedness is irrelevant to the low half. Then go to DONE.
- DIV: restoring division on magnitudes (absolute values for div/rem, raw for divu/remu). One quotient bit per cycle, 64 cycles, using a 65-bit partial remainder. Then go to FIX.
- FIX, signed ops only:
  - quotient negated iff sign(a) != sign(b);
  - remainder takes sign of a;
  - unsigned ops pass through unchanged.
- FIX latches `result` (quotient for div/divu, remainder for rem/remu) and goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Special results:
  - divide by zero: quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=a;
  - overflow: quotient=0x8000_0000_0000_0000, remainder=0.
- Arithmetic is modulo 2^64; no exceptions are raised.
- start outside IDLE is ignored; the issuing stage must hold the instruction while busy.
- flush: the next edge forces IDLE from any state. No done is produced and `result` is not updated. Flush wins over a simultaneous start.
- reset: state=IDLE, busy=0, done=0, result=0, counter=0. Reset wins over flush and start, including mid-operation.

## Timing
- Take an accepted start in cycle t.
- Iterative mul: MUL in t+1..t+64; done=1 and result valid in t+65.
- Normal div/rem: DIV in t+1..t+64, FIX in t+65; done=1 in t+66.
- Divide-by-zero / overflow: done=1 in t+1.
- busy is high from t+1 through the DONE cycle inclusive. It is low in cycle t, so the decode stage sees the stall one cycle after issue and must treat the issue cycle as consumed.
- A new start may be accepted in the cycle after DONE (back-to-back issue allowed).
- done and busy are registered outputs with no combinational path from inputs.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - mul is a single-cycle 64x64 to low-64 multiply;
  - IDLE + start(mul) goes directly to DONE, so done=1 in t+1;
  - MUL state is unreachable;
  - divide path is unchanged.
- MULDIV_FAST_MUL_EN undefined: 64-cycle iterative mul as above, with no wide multiplier inferred.

## Test plan
- mul a=7, b=0xFFFF_FFFF_FFFF_FFFD (-3) -> result 0xFFFF_FFFF_FFFF_FFEB (-21), done in t+65 (t+1 with MULDIV_FAST_MUL_EN).
- div a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3) at t+66; rem same operands -> 0xFFFF_FFFF_FFFF_FFFF (-1); divu a=100, b=7 -> 14; remu -> 2.
- divu a=5, b=0 -> 0xFFFF_FFFF_FFFF_FFFF at t+1; remu a=5, b=0 -> 5 at t+1; busy high only in t+1.
- div a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000 at t+1; rem same operands -> 0.
- Start div, pulse flush at t+20 -> busy=0 at t+21, no done, result unchanged. Start at t+21 with mul 3*4 -> 12 completes normally.
- During busy, drive start with different operands and op; also assert reset mid-DIV -> the start is ignored, the original result completes, and reset returns all outputs to 0 on the next edge.
